// File: rtl/fifo_1r1w_flags.sv
`default_nettype none
// ============================================================================
// Module      : fifo_1r1w_flags
// Description : Single-clock first-word-fall-through FIFO for any depth
//               (power-of-two or not). The producer side is a valid/ready
//               handshake and the consumer side is valid/yumi. The FIFO also
//               reports its occupancy, almost-full and almost-empty flags,
//               and a sticky protocol-error flag.
// Ports       :
//   clk_i           in   clock; all state updates on the rising edge
//   reset_n_i       in   synchronous reset, active-low
//   data_i          in   enqueue data
//   valid_i         in   enqueue request
//   ready_o         out  space available (enqueue = valid_i & ready_o)
//   valid_o         out  head entry present on data_o
//   data_o          out  head entry (meaningful only while valid_o = 1)
//   yumi_i          in   consumer takes the head this cycle
//   count_o         out  current occupancy, 0..depth_p
//   almost_full_o   out  count_o >= almost_full_p
//   almost_empty_o  out  count_o <= almost_empty_p
//   err_o           out  sticky: yumi_i seen while valid_o = 0
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_1r1w_flags #(
    parameter int width_p        = 8,
    parameter int depth_p        = 6,
    parameter int almost_full_p  = depth_p - 1,
    parameter int almost_empty_p = 1
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [width_p-1:0]           data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic                         valid_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         yumi_i,
    output logic [$clog2(depth_p+1)-1:0] count_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o,
    output logic                         err_o
);

    localparam int c_PTR_W = ($clog2(depth_p) < 1) ? 1 : $clog2(depth_p);
    localparam int c_CNT_W = $clog2(depth_p + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(depth_p - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(depth_p);
    localparam logic [c_CNT_W-1:0] c_CNT_AF   = c_CNT_W'(almost_full_p);
    localparam logic [c_CNT_W-1:0] c_CNT_AE   = c_CNT_W'(almost_empty_p);

    logic [width_p-1:0] r_mem [depth_p];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_err;

    logic w_ready;
    logic w_valid;
    logic w_enq;
    logic w_deq;

    // Full/empty come from the count register only; ready never looks at
    // yumi_i, so a full FIFO refuses data even while it is being drained.
    assign w_ready = (r_count != c_CNT_FULL);
    assign w_valid = (r_count != '0);
    assign w_enq   = valid_i & w_ready;
    assign w_deq   = yumi_i & w_valid;

    // Storage is not reset; stale words are never visible because valid_o
    // is derived from the cleared count.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers wrap explicitly at depth_p-1 so non-power-of-two depths work.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (yumi_i && !w_valid) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ready_o        = w_ready;
    assign valid_o        = w_valid;
    assign data_o         = r_mem[r_rd_ptr];
    assign count_o        = r_count;
    assign almost_full_o  = (r_count >= c_CNT_AF);
    assign almost_empty_o = (r_count <= c_CNT_AE);
    assign err_o          = r_err;

endmodule
`default_nettype wire

// File: doc/fifo_1r1w_flags.md
# fifo_1r1w_flags

Parametrised single-clock first-in/first-out buffer with first-word fall-through, for any depth including non-power-of-two depths. Accepts on a valid/ready input and delivers on a valid/yumi output. Adds an occupancy count, programmable almost-full/almost-empty flags and a sticky protocol-error flag. Sits between streaming stages wherever the elastic buffering needs occupancy visibility for upstream throttling.

## Interface
- width_p, 8, data word width in bits (≥1)
- depth_p, 6, number of entries (≥2, any integer, not restricted to powers of two)
- almost_full_p, depth_p-1, almost_full_o asserts when count ≥ this value (1..depth_p)
- almost_empty_p, 1, almost_empty_o asserts when count ≤ this value (0..depth_p-1)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- reset_n_i  in  1  synchronous reset, active-low
- data_i  in  width_p  enqueue data
- valid_i  in  1  enqueue request
- ready_o  out  1  space available; enqueue occurs when valid_i & ready_o
- valid_o  out  1  head entry present on data_o
- data_o  out  width_p  head entry, meaningful only while valid_o=1
- yumi_i  in  1  consumer takes head this cycle; legal only when valid_o=1
- count_o  out  $clog2(depth_p+1)  current occupancy, 0..depth_p
- almost_full_o  out  1  count_o ≥ almost_full_p
- almost_empty_o  out  1  count_o ≤ almost_empty_p
- err_o  out  1  sticky: yumi_i seen while valid_o=0

## Operation
- Storage: depth_p × width_p register array. Write pointer wr_ptr, read pointer rd_ptr, and count register.
- Pointer width is $clog2(depth_p), minimum 1.
- Pointers increment modulo depth_p: from depth_p-1 they wrap to 0 explicitly, not by natural overflow.
- Full/empty are derived from count, never from pointer equality.
- Enqueue (enq = valid_i & ready_o): mem[wr_ptr] <= data_i, wr_ptr advances.
- Dequeue (deq = yumi_i & valid_o): rd_ptr advances.
- Count update: count +1 on enq only, -1 on deq only, unchanged on both or neither.
- ready_o = (count != depth_p). This is combinational from registered state only and never depends on yumi_i. No enqueue into a full FIFO, even with a simultaneous dequeue.
- valid_o = (count != 0). data_o = mem[rd_ptr], combinational read (fall-through). No bypass: an enqueue into an empty FIFO is visible the next cycle.
- Simultaneous enq and deq with 0<count<depth_p: both pointers advance, count holds, data ordering is preserved.
- yumi_i while valid_o=0: ignored (no pointer or count change), and err_o sets.
- err_o stays 1 until reset.
- valid_i while ready_o=0: not an error, data is dropped by the handshake. The producer must hold the data.
- Flags are combinational compares on the count register, so they are glitch-free relative to the clock.
- Reset (reset_n_i=0 at a rising edge): wr_ptr, rd_ptr, count and err_o clear. Memory contents are not cleared.
  - Reset overrides any enq/deq in the same cycle.
  - Reset mid-stream discards all stored entries.

## Timing
- Outputs during and immediately after reset:
  - ready_o=1, valid_o=0, count_o=0, almost_empty_o=1 (almost_empty_p≥0)
  - almost_full_o=0 (almost_full_p≥1)
  - err_o=0
  - data_o undefined
- Enqueue latency: data accepted at edge N appears on data_o with valid_o=1 after edge N, provided all earlier entries are drained.
- Dequeue: head removed at the edge where yumi_i=1. The next entry is on data_o after that edge.
- ready_o reflects a dequeue one cycle later. Full→not-full takes 1 cycle.
- Throughput: one enqueue and one dequeue per cycle sustained at any occupancy except full (no enqueue) and empty (no dequeue).
- count_o, almost_full_o and almost_empty_o change only after a rising edge.

## Test plan
- Reset, then depth_p=6 width_p=8: enqueue 0x01..0x06 back-to-back with yumi_i=0.
  - Required: ready_o falls after the 6th edge, count_o=6, almost_full_o=1 from count 5.
  - A 7th valid_i with 0x07 is not accepted.
- From full, assert yumi_i for 6 cycles.
  - Required: data_o sequence 0x01..0x06, valid_o=0 and almost_empty_o=1 afterwards, count_o=0.
  - ready_o is already 1 in the cycle after the first yumi.
- Wrap-around at depth_p=6: 20 cycles of continuous enq+deq at count=3 with an incrementing pattern.
  - Required: output order is exact, count_o stays 3, pointers wrap 5→0 with no lost or duplicated word.
- Full with valid_i=1 and yumi_i=1 in the same cycle.
  - Required: dequeue only, count_o 6→5, the offered word is not stored.
  - The same word is accepted on the next cycle.
- yumi_i=1 while empty.
  - Required: err_o=1 next cycle and held, count_o stays 0, a subsequent enqueue behaves normally.
- Assert reset_n_i=0 for 1 cycle with count_o=4 and enq/deq both active.
  - Required: count_o=0, valid_o=0, ready_o=0→1 as applicable, err_o=0.
  - Next enqueued word 0xA5 is the first one dequeued.
